// File: rtl/rand_dice_roller.sv
// Multi-die random roller: rolls 1..NUM_DICE dice of one type per inc rising edge,
// with faces drawn from a free-running Galois LFSR and uniformised by rejection sampling.
module rand_dice_roller #(
   parameter int unsigned NUM_DICE  = 4,
   parameter int unsigned OUT_W     = 8,
   parameter int unsigned LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
   parameter int unsigned MAX_TRIES = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  inc,
   input  logic [2:0]                            die_type,
   input  logic [$clog2(NUM_DICE+1)-1:0]         num_dice,
   output logic                                  busy,
   output logic                                  valid,
   output logic [NUM_DICE*OUT_W-1:0]             dice_out,
   output logic [OUT_W+$clog2(NUM_DICE)-1:0]     sum
);

   localparam int unsigned CNT_W = $clog2(NUM_DICE + 1);
   localparam int unsigned SUM_W = OUT_W + $clog2(NUM_DICE);
   localparam int unsigned IDX_W = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
   localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

   state_t                    state, state_n;
   logic [LFSR_W-1:0]         lfsr;
   logic                      inc_r, inc_q;
   logic [2:0]                dtype_q, dtype_n;
   logic [CNT_W-1:0]          count_q, count_n, cnt_req;
   logic [IDX_W-1:0]          idx, idx_n;
   logic [TRY_W-1:0]          tries, tries_n;
   logic [SUM_W-1:0]          acc, acc_n, sum_n;
   logic [NUM_DICE*OUT_W-1:0] dice_n;
   logic                      busy_n, valid_n;
   logic                      req;
   logic [6:0]                sides, raw, face;
   logic [2:0]                k;
   logic                      accept, last_try, last_die;

   // Free-running Galois LFSR; never leaves the nonzero cycle from a nonzero seed
   always_ff @(posedge clk) begin
      if (reset) lfsr <= SEED;
      else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ TAPS;
      else lfsr <= lfsr >> 1;
   end

   assign req = inc_r & ~inc_q & (state == IDLE);

   // Face geometry of the latched die type: number of sides and bits drawn per attempt
   always_comb begin
      sides = 7'd4;
      k     = 3'd2;
      case (dtype_q)
         3'd0: begin sides = 7'd4;   k = 3'd2; end
         3'd1: begin sides = 7'd6;   k = 3'd3; end
         3'd2: begin sides = 7'd8;   k = 3'd3; end
         3'd3: begin sides = 7'd10;  k = 3'd4; end
         3'd4: begin sides = 7'd12;  k = 3'd4; end
         3'd5: begin sides = 7'd20;  k = 3'd5; end
         3'd6: begin sides = 7'd100; k = 3'd7; end
         default: begin sides = 7'd2; k = 3'd1; end
      endcase
      raw      = lfsr[6:0] & 7'((8'd1 << k) - 8'd1);
      accept   = raw < sides;
      face     = accept ? raw + 7'd1 : raw - sides + 7'd1;
      last_try = (tries == TRY_W'(MAX_TRIES - 1));
      last_die = (CNT_W'(idx) == count_q - CNT_W'(1));
   end

   always_comb begin
      if (num_dice == '0) cnt_req = CNT_W'(1);
      else if (num_dice > CNT_W'(NUM_DICE)) cnt_req = CNT_W'(NUM_DICE);
      else cnt_req = num_dice;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n = state;
      busy_n  = busy;
      valid_n = 1'b0;
      dice_n  = dice_out;
      sum_n   = sum;
      acc_n   = acc;
      idx_n   = idx;
      tries_n = tries;
      dtype_n = dtype_q;
      count_n = count_q;
      case (state)
         IDLE: begin
            if (req) begin
               dtype_n = die_type;
               count_n = cnt_req;
               acc_n   = '0;
               idx_n   = '0;
               tries_n = '0;
               busy_n  = 1'b1;
               for (int i = 0; i < NUM_DICE; i++) begin
                  if (CNT_W'(i) >= cnt_req) dice_n[i*OUT_W +: OUT_W] = '0;
               end
               state_n = ROLL;
            end
         end
         ROLL: begin
            if (accept || last_try) begin
               for (int i = 0; i < NUM_DICE; i++) begin
                  if (IDX_W'(i) == idx) dice_n[i*OUT_W +: OUT_W] = OUT_W'(face);
               end
               acc_n   = acc + SUM_W'(face);
               idx_n   = idx + IDX_W'(1);
               tries_n = '0;
               if (last_die) begin
                  sum_n   = acc_n;
                  valid_n = 1'b1;
                  busy_n  = 1'b0;
                  state_n = DONE;
               end
            end else begin
               tries_n = tries + TRY_W'(1);
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         inc_r    <= 1'b0;
         inc_q    <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         dice_out <= '0;
         sum      <= '0;
         acc      <= '0;
         idx      <= '0;
         tries    <= '0;
         dtype_q  <= '0;
         count_q  <= '0;
      end else begin
         state    <= state_n;
         inc_r    <= inc;
         inc_q    <= inc_r;
         busy     <= busy_n;
         valid    <= valid_n;
         dice_out <= dice_n;
         sum      <= sum_n;
         acc      <= acc_n;
         idx      <= idx_n;
         tries    <= tries_n;
         dtype_q  <= dtype_n;
         count_q  <= count_n;
      end
   end

endmodule

// File: tb/tb_rand_dice_roller.sv
// Bench for rand_dice_roller: reference LFSR + rejection model feeds a scoreboard
// checked against each valid pulse.
module tb_rand_dice_roller;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [15:0] TAPS = 16'hB400;

   logic        clk = 1'b0;
   logic        reset;
   logic        inc;
   logic [2:0]  die_type;
   logic [2:0]  num_dice;
   logic        busy;
   logic        valid;
   logic [31:0] dice_out;
   logic [9:0]  sum;

   int errors = 0;
   int checks = 0;
   int vcnt   = 0;

   typedef struct {
      logic [31:0] d;
      logic [9:0]  s;
      int          lat;
      int          cnt;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mlfsr;

   rand_dice_roller dut (
      .clk(clk), .reset(reset), .inc(inc), .die_type(die_type), .num_dice(num_dice),
      .busy(busy), .valid(valid), .dice_out(dice_out), .sum(sum)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   always @(posedge clk) mlfsr <= reset ? SEED : step(mlfsr);

   always @(negedge clk) if (valid === 1'b1) vcnt++;

   function automatic void predict(input logic [15:0] s0, input logic [2:0] dt,
                                   input logic [2:0] nd, output exp_t e);
      int sides, k, raw, face, t, cyc;
      bit got;
      logic [15:0] s;
      case (dt)
         3'd0: begin sides = 4;   k = 2; end
         3'd1: begin sides = 6;   k = 3; end
         3'd2: begin sides = 8;   k = 3; end
         3'd3: begin sides = 10;  k = 4; end
         3'd4: begin sides = 12;  k = 4; end
         3'd5: begin sides = 20;  k = 5; end
         3'd6: begin sides = 100; k = 7; end
         default: begin sides = 2; k = 1; end
      endcase
      e.cnt = (nd == 0) ? 1 : ((nd > 4) ? 4 : int'(nd));
      e.d = '0;
      e.s = '0;
      s = s0;
      cyc = 0;
      face = 0;
      for (int i = 0; i < e.cnt; i++) begin
         t = 0;
         got = 0;
         while (!got) begin
            raw = int'(s) & ((1 << k) - 1);
            s = step(s);
            cyc++;
            if (raw < sides) begin face = raw + 1; got = 1; end
            else if (t == 7) begin face = raw - sides + 1; got = 1; end
            else t++;
         end
         e.d[i*8 +: 8] = 8'(face);
         e.s = e.s + 10'(face);
      end
      e.lat = cyc + 1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one request (inc high 2 cycles), push the model prediction, then check at valid
   task automatic roll(input logic [2:0] dt, input logic [2:0] nd, output int lat);
      exp_t e, got;
      int n;
      die_type = dt;
      num_dice = nd;
      inc = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      inc = 1'b0;
      predict(mlfsr, dt, nd, e);
      sb.push_back(e);
      n = 1;
      while (valid !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      lat = n;
      got = sb.pop_front();
      if (valid !== 1'b1) begin
         chk("valid_timeout", 64'(valid), 64'd1);
      end else begin
         chk("latency", 64'(n), 64'(got.lat));
         chk("dice", 64'(dice_out), 64'(got.d));
         chk("sum", 64'(sum), 64'(got.s));
         chk("busy_done", 64'(busy), 64'd0);
         for (int i = 0; i < got.cnt; i++) begin
            chk("face_nonzero", 64'(dice_out[i*8 +: 8] != 8'd0), 64'd1);
         end
      end
      @(posedge clk); #1;
      chk("valid_one_cycle", 64'(valid), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, v0;
      logic [6:0] f;
      reset = 1'b1;
      inc = 1'b0;
      die_type = 3'd0;
      num_dice = 3'd0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_dice", 64'(dice_out), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_lfsr", 64'(dut.lfsr), 64'(SEED));
      repeat (3) @(posedge clk);
      #1;
      chk("lfsr_step", 64'(dut.lfsr), 64'(mlfsr));

      // d8 x4: power of two, no rejection
      roll(3'd2, 3'd4, lat);
      chk("d8_latency5", 64'(lat), 64'd5);
      for (int i = 0; i < 4; i++) begin
         f = 7'(dice_out[i*8 +: 8]);
         chk("d8_range", 64'(f >= 7'd1 && f <= 7'd8), 64'd1);
      end
      chk("d8_sum_total", 64'(sum), 64'(dice_out[7:0] + dice_out[15:8] + dice_out[23:16] + dice_out[31:24]));
      repeat (2) @(posedge clk);
      #1;

      // d100 x3, many rolls
      for (int r = 0; r < 200; r++) begin
         roll(3'd6, 3'd3, lat);
         for (int i = 0; i < 3; i++) begin
            f = 7'(dice_out[i*8 +: 8]);
            chk("d100_range", 64'(f >= 7'd1 && f <= 7'd100), 64'd1);
         end
         chk("d100_slot3", 64'(dice_out[31:24]), 64'd0);
         chk("d100_sum_max", 64'(sum <= 10'd300), 64'd1);
         chk("d100_lat_max", 64'(lat <= 25), 64'd1);
         repeat (r % 3) @(posedge clk);
         #1;
      end

      // d6 with num_dice=0 rolls exactly one die
      roll(3'd1, 3'd0, lat);
      chk("d6_slots_hi", 64'(dice_out[31:8]), 64'd0);
      chk("d6_sum_face", 64'(sum), 64'(dice_out[7:0]));
      chk("d6_range", 64'(dice_out[7:0] >= 8'd1 && dice_out[7:0] <= 8'd6), 64'd1);
      chk("d6_latency", 64'(lat), 64'(sb.size() == 0 ? lat : 0));

      // inc held high: a single roll
      repeat (3) @(posedge clk);
      #1;
      v0 = vcnt;
      die_type = 3'd6;
      num_dice = 3'd4;
      inc = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("hold_one_pulse", 64'(vcnt - v0), 64'd1);
      inc = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // toggles during busy are ignored
      v0 = vcnt;
      inc = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("toggle_busy", 64'(busy), 64'd1);
      inc = 1'b0;
      @(posedge clk); #1;
      inc = 1'b1;
      @(posedge clk); #1;
      inc = 1'b0;
      repeat (45) @(posedge clk);
      #1;
      chk("toggle_one_pulse", 64'(vcnt - v0), 64'd1);

      // reset during the second ROLL cycle of d20 x4
      v0 = vcnt;
      die_type = 3'd5;
      num_dice = 3'd4;
      inc = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      inc = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_valid", 64'(valid), 64'd0);
      chk("abort_dice", 64'(dice_out), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_pulse", 64'(vcnt - v0), 64'd0);
      roll(3'd5, 3'd4, lat);
      chk("after_abort_pulse", 64'(vcnt - v0), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
